control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 45 ++++
 rtl/mfc_timer.sv | 29 ++
 rtl/control_unit.sv | 188 ++++++++++++++++++
 tb/tb_control_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared definitions for the control unit
// Contents: op encodings, FSM state enumeration, IR field positions,
//           default MFC timeout, one-hot register select helper.
package cu_pkg;

   localparam int MFC_TIMEOUT_DEFAULT = 255;

   // IR field positions
   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int RD_HI = 11;
   localparam int RD_LO = 10;
   localparam int RS_HI = 9;
   localparam int RS_LO = 8;
   localparam int FN_HI = 7;
   localparam int FN_LO = 5;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MOV   = 4'd1,
      OP_ALU   = 4'd2,
      OP_LOAD  = 4'd3,
      OP_STORE = 4'd4,
      OP_IN    = 4'd5,
      OP_OUT   = 4'd6,
      OP_HALT  = 4'd7
   } op_t;

   typedef enum logic [4:0] {
      ST_F0, ST_F1, ST_F2, ST_F3, ST_DECODE,
      ST_MOV,
      ST_A1, ST_A2, ST_A3, ST_A4,
      ST_L1, ST_L2, ST_L3, ST_L4,
      ST_S1, ST_S2, ST_S3,
      ST_I1, ST_I2,
      ST_OUT,
      ST_HALTED,
      ST_FAULT
   } state_t;

   function automatic logic [3:0] reg_sel(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mfc_timer.sv
// rtl/mfc_timer.sv - counts cycles spent waiting for memory function complete
// Ports: clk, rst (sync, active-high), run (high in a wait state),
//        expired (high on the TIMEOUT-th consecutive wait cycle).
module mfc_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   // count holds the number of wait cycles already completed, so it reads 0
   // on the first wait cycle; any non-wait cycle clears it.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign expired = run && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/decode/execute control unit
// Ports: clk, rst (sync, active-high), bus (IR source), MFC (memory done);
//        ALU strobes (opCode, ALUin1/2, ALU_outlach, ALU_outEN),
//        register strobes (G_in, G_out one-hot), PC (PC_EN, pc_inc),
//        I/O (P0_in, P1_in, P1_out), memory (MAR_EN, MDR_EN_write,
//        MDR_EN_read, MDR_out, mem_EN, mem_RW), status (halted, fault, illegal).
module control_unit
   import cu_pkg::*;
#(
   parameter int MFC_TIMEOUT = MFC_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bus,
   input  logic        MFC,
   output logic [2:0]  opCode,
   output logic        ALUin1,
   output logic        ALUin2,
   output logic        ALU_outlach,
   output logic        ALU_outEN,
   output logic [3:0]  G_in,
   output logic [3:0]  G_out,
   output logic        PC_EN,
   output logic        pc_inc,
   output logic        P0_in,
   output logic        P1_in,
   output logic        P1_out,
   output logic        MAR_EN,
   output logic        MDR_EN_write,
   output logic        MDR_EN_read,
   output logic        MDR_out,
   output logic        mem_EN,
   output logic        mem_RW,
   output logic        halted,
   output logic        fault,
   output logic        illegal
);

   state_t      state;
   state_t      state_next;
   logic [15:0] ir;
   op_t         op;
   logic [1:0]  rd;
   logic [1:0]  rs;
   logic [2:0]  fn;
   logic        waiting;
   logic        expired;
   logic        unused_ir_bits;

   assign op             = op_t'(ir[OP_HI:OP_LO]);
   assign rd             = ir[RD_HI:RD_LO];
   assign rs             = ir[RS_HI:RS_LO];
   assign fn             = ir[FN_HI:FN_LO];
   assign unused_ir_bits = ^ir[4:0];

   assign waiting = (state == ST_F1) || (state == ST_L2) || (state == ST_S3);

   mfc_timer #(
      .TIMEOUT (MFC_TIMEOUT)
   ) u_mfc_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (waiting),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ir <= '0;
      end else if (state == ST_F3) begin
         ir <= bus;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_F0;
      end else begin
         state <= state_next;
      end
   end

   // MFC is only looked at in the three wait states; a completion on the
   // timeout cycle itself still wins over the fault.
   always_comb begin
      state_next = state;
      case (state)
         ST_F0:     state_next = ST_F1;
         ST_F1: begin
            if (MFC)          state_next = ST_F2;
            else if (expired) state_next = ST_FAULT;
         end
         ST_F2:     state_next = ST_F3;
         ST_F3:     state_next = ST_DECODE;
         ST_DECODE: begin
            case (op)
               OP_NOP:   state_next = ST_F0;
               OP_MOV:   state_next = ST_MOV;
               OP_ALU:   state_next = ST_A1;
               OP_LOAD:  state_next = ST_L1;
               OP_STORE: state_next = ST_S1;
               OP_IN:    state_next = ST_I1;
               OP_OUT:   state_next = ST_OUT;
               OP_HALT:  state_next = ST_HALTED;
               default:  state_next = ST_F0;
            endcase
         end
         ST_MOV:    state_next = ST_F0;
         ST_A1:     state_next = ST_A2;
         ST_A2:     state_next = ST_A3;
         ST_A3:     state_next = ST_A4;
         ST_A4:     state_next = ST_F0;
         ST_L1:     state_next = ST_L2;
         ST_L2: begin
            if (MFC)          state_next = ST_L3;
            else if (expired) state_next = ST_FAULT;
         end
         ST_L3:     state_next = ST_L4;
         ST_L4:     state_next = ST_F0;
         ST_S1:     state_next = ST_S2;
         ST_S2:     state_next = ST_S3;
         ST_S3: begin
            if (MFC)          state_next = ST_F0;
            else if (expired) state_next = ST_FAULT;
         end
         ST_I1:     state_next = ST_I2;
         ST_I2:     state_next = ST_F0;
         ST_OUT:    state_next = ST_F0;
         ST_HALTED: state_next = ST_HALTED;
         ST_FAULT:  state_next = ST_FAULT;
         default:   state_next = ST_F0;
      endcase
   end

   // Outputs decode the registered state and IR only. While rst is applied
   // everything is held quiet so the reset cycle never drives the bus.
   always_comb begin
      opCode       = 3'b000;
      ALUin1       = 1'b0;
      ALUin2       = 1'b0;
      ALU_outlach  = 1'b0;
      ALU_outEN    = 1'b0;
      G_in         = 4'b0000;
      G_out        = 4'b0000;
      PC_EN        = 1'b0;
      pc_inc       = 1'b0;
      P0_in        = 1'b0;
      P1_in        = 1'b0;
      P1_out       = 1'b0;
      MAR_EN       = 1'b0;
      MDR_EN_write = 1'b0;
      MDR_EN_read  = 1'b0;
      MDR_out      = 1'b0;
      mem_EN       = 1'b0;
      mem_RW       = 1'b0;
      halted       = 1'b0;
      fault        = 1'b0;
      illegal      = 1'b0;
      if (!rst) begin
         case (state)
            ST_F0:     begin PC_EN = 1'b1; MAR_EN = 1'b1; end
            ST_F1:     begin mem_EN = 1'b1; mem_RW = 1'b1; end
            ST_F2:     MDR_EN_read = 1'b1;
            ST_F3:     begin MDR_out = 1'b1; pc_inc = 1'b1; end
            ST_DECODE: illegal = (ir[OP_HI:OP_LO] > 4'd7);
            ST_MOV:    begin G_out = reg_sel(rs); G_in = reg_sel(rd); end
            ST_A1:     begin opCode = fn; G_out = reg_sel(rd); ALUin1 = 1'b1; end
            ST_A2:     begin opCode = fn; G_out = reg_sel(rs); ALUin2 = 1'b1; end
            ST_A3:     begin opCode = fn; ALU_outlach = 1'b1; end
            ST_A4:     begin opCode = fn; ALU_outEN = 1'b1; G_in = reg_sel(rd); end
            ST_L1:     begin G_out = reg_sel(rs); MAR_EN = 1'b1; end
            ST_L2:     begin mem_EN = 1'b1; mem_RW = 1'b1; end
            ST_L3:     MDR_EN_read = 1'b1;
            ST_L4:     begin MDR_out = 1'b1; G_in = reg_sel(rd); end
            ST_S1:     begin G_out = reg_sel(rd); MAR_EN = 1'b1; end
            ST_S2:     begin G_out = reg_sel(rs); MDR_EN_write = 1'b1; end
            ST_S3:     begin mem_EN = 1'b1; mem_RW = 1'b0; end
            ST_I1:     P1_in = 1'b1;
            ST_I2:     begin P1_out = 1'b1; G_in = reg_sel(rd); end
            ST_OUT:    begin G_out = reg_sel(rs); P0_in = 1'b1; end
            ST_HALTED: halted = 1'b1;
            ST_FAULT:  fault = 1'b1;
            default:   ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;

   typedef logic [28:0] ov_t;

   typedef struct {
      ov_t   val;
      string tag;
   } exp_t;

   localparam ov_t B_ILLEGAL = ov_t'(1) << 0;
   localparam ov_t B_FAULT   = ov_t'(1) << 1;
   localparam ov_t B_HALTED  = ov_t'(1) << 2;
   localparam ov_t B_MEM_RW  = ov_t'(1) << 3;
   localparam ov_t B_MEM_EN  = ov_t'(1) << 4;
   localparam ov_t B_MDR_OUT = ov_t'(1) << 5;
   localparam ov_t B_MDR_RD  = ov_t'(1) << 6;
   localparam ov_t B_MDR_WR  = ov_t'(1) << 7;
   localparam ov_t B_MAR_EN  = ov_t'(1) << 8;
   localparam ov_t B_P1_OUT  = ov_t'(1) << 9;
   localparam ov_t B_P1_IN   = ov_t'(1) << 10;
   localparam ov_t B_P0_IN   = ov_t'(1) << 11;
   localparam ov_t B_PC_INC  = ov_t'(1) << 12;
   localparam ov_t B_PC_EN   = ov_t'(1) << 13;
   localparam ov_t B_ALU_EN  = ov_t'(1) << 22;
   localparam ov_t B_ALU_LT  = ov_t'(1) << 23;
   localparam ov_t B_ALU_IN2 = ov_t'(1) << 24;
   localparam ov_t B_ALU_IN1 = ov_t'(1) << 25;
   localparam ov_t NONE      = '0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bus = 16'h0000;
   logic        MFC = 1'b0;
   logic [2:0]  opCode;
   logic        ALUin1, ALUin2, ALU_outlach, ALU_outEN;
   logic [3:0]  G_in, G_out;
   logic        PC_EN, pc_inc, P0_in, P1_in, P1_out;
   logic        MAR_EN, MDR_EN_write, MDR_EN_read, MDR_out, mem_EN, mem_RW;
   logic        halted, fault, illegal;
   ov_t         obs;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   control_unit #(.MFC_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .bus(bus), .MFC(MFC),
      .opCode(opCode), .ALUin1(ALUin1), .ALUin2(ALUin2),
      .ALU_outlach(ALU_outlach), .ALU_outEN(ALU_outEN),
      .G_in(G_in), .G_out(G_out), .PC_EN(PC_EN), .pc_inc(pc_inc),
      .P0_in(P0_in), .P1_in(P1_in), .P1_out(P1_out),
      .MAR_EN(MAR_EN), .MDR_EN_write(MDR_EN_write), .MDR_EN_read(MDR_EN_read),
      .MDR_out(MDR_out), .mem_EN(mem_EN), .mem_RW(mem_RW),
      .halted(halted), .fault(fault), .illegal(illegal)
   );

   assign obs = {opCode, ALUin1, ALUin2, ALU_outlach, ALU_outEN, G_in, G_out,
                 PC_EN, pc_inc, P0_in, P1_in, P1_out,
                 MAR_EN, MDR_EN_write, MDR_EN_read, MDR_out, mem_EN, mem_RW,
                 halted, fault, illegal};

   function automatic ov_t gin(input int n);
      return ov_t'(1) << (18 + n);
   endfunction

   function automatic ov_t gout(input int n);
      return ov_t'(1) << (14 + n);
   endfunction

   function automatic ov_t opc(input logic [2:0] f);
      return ov_t'(f) << 26;
   endfunction

   // Monitor: compares the expected vector for the current cycle, and checks
   // bus-driver exclusivity on every cycle.
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if ($countones({ALU_outEN, G_out, PC_EN, P1_out, MDR_out}) > 1) begin
         errors++;
         $display("FAIL bus_exclusive @%0t: got %b allowed at most one driver", $time,
                  {ALU_outEN, G_out, PC_EN, P1_out, MDR_out});
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs !== e.val) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", e.tag, $time, obs, e.val);
         end
      end
   end

   // One clock cycle: drive inputs for this cycle and queue what the outputs
   // must show during it.
   task automatic cyc(input ov_t e, input string tag, input logic m = 1'b0,
                      input logic r = 1'b0, input logic [15:0] b = 16'h0000);
      exp_t x;
      @(posedge clk);
      #1;
      MFC = m;
      rst = r;
      bus = b;
      x.val = e;
      x.tag = tag;
      exp_q.push_back(x);
   endtask

   task automatic fetch(input logic [15:0] instr, input int waits, input ov_t dec_exp,
                        input logic mfc_f0 = 1'b0);
      cyc(B_PC_EN | B_MAR_EN, "F0", mfc_f0);
      for (int i = 0; i < waits; i++) cyc(B_MEM_EN | B_MEM_RW, "F1", (i == waits - 1));
      cyc(B_MDR_RD, "F2");
      cyc(B_MDR_OUT | B_PC_INC, "F3", 1'b0, 1'b0, instr);
      cyc(dec_exp, "DECODE");
   endtask

   task automatic alu_exec(input int rd, input int rs, input logic [2:0] f);
      cyc(opc(f) | gout(rd) | B_ALU_IN1, "A1");
      cyc(opc(f) | gout(rs) | B_ALU_IN2, "A2");
      cyc(opc(f) | B_ALU_LT, "A3");
      cyc(opc(f) | B_ALU_EN | gin(rd), "A4");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset held for two edges; outputs quiet throughout
      cyc(NONE, "reset_apply", 1'b0, 1'b1);
      cyc(NONE, "reset_hold", 1'b1, 1'b1);

      // MOV G1 <- G2
      fetch(16'h1600, 1, NONE);
      cyc(gout(2) | gin(1), "MOV");

      // ALU G0 <- G0 fn G3, fn=0
      fetch(16'h2300, 1, NONE);
      alu_exec(0, 3, 3'b000);

      // LOAD G2 <- mem[G1], MFC on third wait cycle
      fetch(16'h3900, 1, NONE);
      cyc(gout(1) | B_MAR_EN, "L1");
      cyc(B_MEM_EN | B_MEM_RW, "L2_w1");
      cyc(B_MEM_EN | B_MEM_RW, "L2_w2");
      cyc(B_MEM_EN | B_MEM_RW, "L2_w3", 1'b1);
      cyc(B_MDR_RD, "L3");
      cyc(B_MDR_OUT | gin(2), "L4");

      // ALU G1 <- G1 fn G2, fn=5
      fetch(16'h26A0, 1, NONE);
      alu_exec(1, 2, 3'b101);

      // STORE mem[G3] <- G0, MFC on second wait cycle
      fetch(16'h4C00, 1, NONE);
      cyc(gout(3) | B_MAR_EN, "S1");
      cyc(gout(0) | B_MDR_WR, "S2");
      cyc(B_MEM_EN, "S3_w1");
      cyc(B_MEM_EN, "S3_w2", 1'b1);

      // IN G2 <- P1
      fetch(16'h5800, 1, NONE);
      cyc(B_P1_IN, "I1");
      cyc(B_P1_OUT | gin(2), "I2");

      // OUT P0 <- G1, stray MFC ignored
      fetch(16'h6100, 1, NONE);
      cyc(gout(1) | B_P0_IN, "OUT", 1'b1);

      // NOP with MFC raised in F0 (must not shorten the wait) and 3 waits
      fetch(16'h0000, 3, NONE, 1'b1);

      // illegal op: pulse in DECODE only, then back to fetch
      fetch(16'hF000, 1, B_ILLEGAL);

      // MFC arriving on the last cycle before timeout still completes
      fetch(16'h0000, 255, NONE);

      // reset during A2
      fetch(16'h2300, 1, NONE);
      cyc(gout(0) | B_ALU_IN1, "A1_pre_rst");
      cyc(NONE, "A2_rst", 1'b0, 1'b1);
      cyc(NONE, "rst_hold_after_A2", 1'b0, 1'b1);

      // HALT: stable for 100 cycles, MFC toggling has no effect
      fetch(16'h7000, 1, NONE);
      for (int i = 0; i < 100; i++) cyc(B_HALTED, "HALTED", logic'(i % 2));
      cyc(NONE, "rst_from_halt", 1'b0, 1'b1);

      // timeout: 255 wait cycles without MFC, then FAULT
      cyc(B_PC_EN | B_MAR_EN, "F0_to");
      for (int i = 0; i < 255; i++) cyc(B_MEM_EN | B_MEM_RW, "F1_to");
      cyc(B_FAULT, "FAULT_1", 1'b1);
      cyc(B_FAULT, "FAULT_2");
      cyc(B_FAULT, "FAULT_3");
      cyc(NONE, "rst_from_fault", 1'b0, 1'b1);
      cyc(B_PC_EN | B_MAR_EN, "F0_after_fault");

      @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
